// File: rtl/uart_rx_fifo_writer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_rx_fifo_writer                                        |
// | Description : Serial UART receiver (8N1, or 8E1 when PARITY_EN is        |
// |               defined) that feeds the write side of a byte FIFO. It runs |
// |               entirely in the wr_clk domain.                             |
// | Ports       : wr_clk     - write-domain clock, rising edge               |
// |               reset_n    - asynchronous active-low reset                 |
// |               rx_in      - asynchronous serial line, idle high           |
// |               fifo_full  - FIFO full flag, sampled at stop-bit sample    |
// |               wr         - one-cycle FIFO write strobe                   |
// |               data_out   - received byte, held until the next wr         |
// |               busy       - receiver is not in IDLE                       |
// |               frame_err  - one-cycle pulse, stop bit sampled low        |
// |               overrun    - one-cycle pulse, good byte dropped (full)     |
// |               parity_err - one-cycle pulse, parity mismatch             |
// | Macro       : PARITY_EN - adds an even-parity bit after the data bits    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module uart_rx_fifo_writer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8
) (
    input  logic                 wr_clk,
    input  logic                 reset_n,
    input  logic                 rx_in,
    input  logic                 fifo_full,
    output logic                 wr,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 parity_err
);

    localparam int c_CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [c_CW-1:0] c_HALF_CNT = c_CW'(CLKS_PER_BIT/2 - 1);
    localparam logic [c_CW-1:0] c_FULL_CNT = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                 r_state;
    logic                   r_rx_meta;
    logic                   r_rx_s;
    logic [c_CW-1:0]        r_cnt;
    logic [c_IW-1:0]        r_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_seen_high;
    logic                   r_busy;
    logic                   r_wr;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_frame_err;
    logic                   r_overrun;
    logic                   w_parity_ok;

`ifdef PARITY_EN
    logic                   r_par_bit;
    logic                   r_parity_err;

    // Even parity: data bits plus parity bit must XOR to zero.
    assign w_parity_ok = ~(^{r_shift, r_par_bit});
    assign parity_err  = r_parity_err;
`else
    assign w_parity_ok = 1'b1;
    assign parity_err  = 1'b0;
`endif

    assign wr        = r_wr;
    assign data_out  = r_data;
    assign busy      = r_busy;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;

    // Two-flop synchroniser; both flops reset to the idle (high) line level.
    always_ff @(posedge wr_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx_in;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge wr_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_seen_high <= 1'b1;
            r_busy      <= 1'b0;
            r_wr        <= 1'b0;
            r_data      <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef PARITY_EN
            r_par_bit    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            // Strobes and error flags are single-cycle pulses.
            r_wr        <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
`ifdef PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                    // After a framing error (possibly a break) the line must
                    // be seen high before a new falling edge is accepted.
                    if (r_rx_s) begin
                        r_seen_high <= 1'b1;
                    end else if (r_seen_high) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end

                S_START: begin
                    if (r_cnt == c_HALF_CNT) begin
                        r_cnt <= '0;
                        r_idx <= '0;
                        if (r_rx_s) begin
                            // Line back high at mid start bit: glitch, ignore.
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    if (r_cnt == c_FULL_CNT) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_idx == c_LAST_IDX) begin
                            r_idx <= '0;
`ifdef PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

`ifdef PARITY_EN
                S_PARITY: begin
                    if (r_cnt == c_FULL_CNT) begin
                        r_cnt     <= '0;
                        r_par_bit <= r_rx_s;
                        r_state   <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif

                S_STOP: begin
                    if (r_cnt == c_FULL_CNT) begin
                        // Return to IDLE at mid stop bit so a start bit that
                        // immediately follows is not missed.
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        if (!r_rx_s) begin
                            r_frame_err <= 1'b1;
                            r_seen_high <= 1'b0;
                        end else if (!w_parity_ok) begin
`ifdef PARITY_EN
                            r_parity_err <= 1'b1;
`endif
                        end else if (fifo_full) begin
                            r_overrun <= 1'b1;
                        end else begin
                            r_wr   <= 1'b1;
                            r_data <= r_shift;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo_writer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_rx_fifo_writer                                     |
// | Description : Directed self-checking bench for uart_rx_fifo_writer with  |
// |               CLKS_PER_BIT = 8. Define PARITY_EN to exercise 8E1 frames.  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_uart_rx_fifo_writer;

    localparam int CPB = 8;
`ifdef PARITY_EN
    localparam int c_FRAME_BITS = 11;
`else
    localparam int c_FRAME_BITS = 10;
`endif
    // Cycles from driving the start bit to the negedge where wr is high.
    localparam int c_WR_LAT = (c_FRAME_BITS - 1) * CPB + 7;

    logic       wr_clk    = 1'b0;
    logic       reset_n   = 1'b0;
    logic       rx_in     = 1'b1;
    logic       fifo_full = 1'b0;
    logic       wr;
    logic [7:0] data_out;
    logic       busy;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int tests_run    = 0;
    int tests_failed = 0;

    int         cyc         = 0;
    int         n_wr        = 0;
    int         n_fe        = 0;
    int         n_ov        = 0;
    int         n_pe        = 0;
    int         n_consec    = 0;
    int         last_wr_cyc = -1;
    logic       prev_wr     = 1'b0;
    logic [7:0] wr_hist[$];

    uart_rx_fifo_writer #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8)
    ) dut (
        .wr_clk     (wr_clk),
        .reset_n    (reset_n),
        .rx_in      (rx_in),
        .fifo_full  (fifo_full),
        .wr         (wr),
        .data_out   (data_out),
        .busy       (busy),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 wr_clk = ~wr_clk;

    always @(posedge wr_clk) cyc++;

    // Event monitor: counts strobes on the falling edge.
    always @(negedge wr_clk) begin
        if (reset_n) begin
            if (wr) begin
                n_wr++;
                wr_hist.push_back(data_out);
                last_wr_cyc = cyc;
                if (prev_wr) n_consec++;
            end
            if (frame_err)  n_fe++;
            if (overrun)    n_ov++;
            if (parity_err) n_pe++;
            prev_wr = wr;
        end else begin
            prev_wr = 1'b0;
        end
    end

    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (CPB) @(posedge wr_clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(posedge wr_clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef PARITY_EN
        drive_bit(^d);
`endif
        drive_bit(stop_b);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (3) @(posedge wr_clk);
        #1;
        tests_run++;
        if ({wr, busy, frame_err, overrun, parity_err, data_out} !== 13'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got wr=%b busy=%b fe=%b ov=%b pe=%b data=%h, want all 0",
                     wr, busy, frame_err, overrun, parity_err, data_out);
        end
        reset_n = 1'b1;
        idle(4);
    endtask

    task automatic test_single_byte;
        int t0, w0, e0;
        t0 = cyc; w0 = n_wr; e0 = n_fe + n_ov + n_pe;
        send_frame(8'hA5, 1'b1);
        idle(4);
        tests_run++;
        if (n_wr - w0 !== 1) begin
            tests_failed++;
            $display("FAIL single_wr_count: got %0d want 1", n_wr - w0);
        end
        tests_run++;
        if (data_out !== 8'hA5) begin
            tests_failed++;
            $display("FAIL single_data: got %h want a5", data_out);
        end
        tests_run++;
        if (last_wr_cyc !== t0 + c_WR_LAT) begin
            tests_failed++;
            $display("FAIL single_latency: wr at cycle %0d want %0d", last_wr_cyc, t0 + c_WR_LAT);
        end
        tests_run++;
        if (n_fe + n_ov + n_pe - e0 !== 0) begin
            tests_failed++;
            $display("FAIL single_errors: got %0d error pulses want 0", n_fe + n_ov + n_pe - e0);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_busy_idle: got %b want 0", busy);
        end
    endtask

    task automatic test_back_to_back;
        int w0;
        w0 = n_wr;
        send_frame(8'h3C, 1'b1);
        send_frame(8'hC3, 1'b1);
        idle(4);
        tests_run++;
        if (n_wr - w0 !== 2) begin
            tests_failed++;
            $display("FAIL b2b_wr_count: got %0d want 2", n_wr - w0);
        end else begin
            tests_run++;
            if (wr_hist[w0] !== 8'h3C || wr_hist[w0+1] !== 8'hC3) begin
                tests_failed++;
                $display("FAIL b2b_data: got %h,%h want 3c,c3", wr_hist[w0], wr_hist[w0+1]);
            end
        end
    endtask

    task automatic test_overrun;
        int w0, o0;
        w0 = n_wr; o0 = n_ov;
        fifo_full = 1'b1;
        send_frame(8'h55, 1'b1);
        idle(4);
        fifo_full = 1'b0;
        tests_run++;
        if (n_ov - o0 !== 1 || n_wr - w0 !== 0) begin
            tests_failed++;
            $display("FAIL overrun_pulse: got overrun=%0d wr=%0d want 1,0", n_ov - o0, n_wr - w0);
        end
        tests_run++;
        if (data_out !== 8'hC3) begin
            tests_failed++;
            $display("FAIL overrun_data_hold: got %h want c3", data_out);
        end
    endtask

    task automatic test_frame_err;
        int w0, f0, o0;
        w0 = n_wr; f0 = n_fe;
        send_frame(8'h81, 1'b0);
        idle(6);
        tests_run++;
        if (n_fe - f0 !== 1 || n_wr - w0 !== 0) begin
            tests_failed++;
            $display("FAIL frame_err_pulse: got fe=%0d wr=%0d want 1,0", n_fe - f0, n_wr - w0);
        end
        // Two-cycle low glitch on an idle line.
        w0 = n_wr; f0 = n_fe; o0 = n_ov;
        rx_in = 1'b0;
        repeat (2) @(posedge wr_clk);
        #1;
        rx_in = 1'b1;
        repeat (2) @(posedge wr_clk);
        #1;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL glitch_busy_start: got %b want 1", busy);
        end
        idle(10);
        tests_run++;
        if (busy !== 1'b0 || n_wr - w0 !== 0 || n_fe - f0 !== 0 || n_ov - o0 !== 0) begin
            tests_failed++;
            $display("FAIL glitch_false_start: got busy=%b wr=%0d fe=%0d ov=%0d want 0,0,0,0",
                     busy, n_wr - w0, n_fe - f0, n_ov - o0);
        end
    endtask

    task automatic test_break;
        int w0, f0;
        w0 = n_wr; f0 = n_fe;
        rx_in = 1'b0;
        repeat (12 * CPB) @(posedge wr_clk);
        #1;
        tests_run++;
        if (n_fe - f0 !== 1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL break_single_fe: got fe=%0d busy=%b want 1,0", n_fe - f0, busy);
        end
        idle(8);
        send_frame(8'h5A, 1'b1);
        idle(4);
        tests_run++;
        if (n_wr - w0 !== 1 || data_out !== 8'h5A) begin
            tests_failed++;
            $display("FAIL break_recover: got wr=%0d data=%h want 1,5a", n_wr - w0, data_out);
        end
    endtask

    task automatic test_reset_midframe;
        int w0;
        w0 = n_wr;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({wr, busy, frame_err, overrun, parity_err, data_out} !== 13'd0) begin
            tests_failed++;
            $display("FAIL midframe_reset_outputs: got wr=%b busy=%b fe=%b ov=%b pe=%b data=%h, want all 0",
                     wr, busy, frame_err, overrun, parity_err, data_out);
        end
        idle(5);
        reset_n = 1'b1;
        idle(6);
        send_frame(8'h12, 1'b1);
        idle(4);
        tests_run++;
        if (n_wr - w0 !== 1 || wr_hist[$] !== 8'h12) begin
            tests_failed++;
            $display("FAIL midframe_reset_recover: got wr=%0d data=%h want 1,12", n_wr - w0, wr_hist[$]);
        end
    endtask

`ifdef PARITY_EN
    task automatic test_parity;
        int w0, p0;
        w0 = n_wr; p0 = n_pe;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(i < 3);
        drive_bit(1'b1);
        drive_bit(1'b1);
        idle(4);
        tests_run++;
        if (n_wr - w0 !== 1 || data_out !== 8'h07 || n_pe - p0 !== 0) begin
            tests_failed++;
            $display("FAIL parity_good: got wr=%0d data=%h pe=%0d want 1,07,0", n_wr - w0, data_out, n_pe - p0);
        end
        w0 = n_wr; p0 = n_pe;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(i < 3);
        drive_bit(1'b0);
        drive_bit(1'b1);
        idle(4);
        tests_run++;
        if (n_wr - w0 !== 0 || n_pe - p0 !== 1) begin
            tests_failed++;
            $display("FAIL parity_bad: got wr=%0d pe=%0d want 0,1", n_wr - w0, n_pe - p0);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_single_byte;
        test_back_to_back;
        test_overrun;
        test_frame_err;
        test_break;
        test_reset_midframe;
`ifdef PARITY_EN
        test_parity;
`else
        tests_run++;
        if (n_pe !== 0) begin
            tests_failed++;
            $display("FAIL parity_err_tied: got %0d pulses want 0", n_pe);
        end
`endif
        tests_run++;
        if (n_consec !== 0) begin
            tests_failed++;
            $display("FAIL no_consecutive_wr: got %0d want 0", n_consec);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
